// File: rtl/time_set_ctrl.sv
// Button synchroniser/debouncer and edit-mode FSM driving the hour/minute/second counters.
// Define AUTO_REPEAT_EN to build held-button auto-repeat on UP/DOWN; without it each press gives one pulse.
module time_set_ctrl #(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int TIMEOUT_S     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       sec_inc_auto,
    output logic       sec_inc_manual,
    output logic       sec_dec_manual,
    output logic       min_inc_manual,
    output logic       min_dec_manual,
    output logic       hour_inc_manual,
    output logic       hour_dec_manual,
    output logic [1:0] edit_sel,
    output logic       blink
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t               state, state_next;
    logic [2:0]           raw, sync_a, sync_b, level, level_d;
    logic [2:0][DB_W-1:0] db_cnt;
    logic [TO_W-1:0]      to_cnt, to_next;
    logic                 mode_press, up_press, dn_press, any_press;
    logic                 up_lvl, dn_lvl, editing, fire_up, fire_dn;
    logic                 inc_pulse, dec_pulse;

    assign raw = {btn_down, btn_up, btn_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Level flips only after DB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            level_d <= '0;
            db_cnt  <= '0;
        end else begin
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    level[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign mode_press = level[0] & ~level_d[0];
    assign up_press   = level[1] & ~level_d[1];
    assign dn_press   = level[2] & ~level_d[2];
    assign any_press  = mode_press | up_press | dn_press;
    assign up_lvl     = level[1];
    assign dn_lvl     = level[2];
    assign editing    = (state != RUN);

    // A press of one direction while the other is held produces nothing.
    assign fire_up = editing & ~mode_press & up_press & ~dn_lvl;
    assign fire_dn = editing & ~mode_press & dn_press & ~up_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        to_next    = to_cnt;
        if (mode_press) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                default:  state_next = RUN;
            endcase
        end
        if (state == RUN || any_press) begin
            to_next = '0;
        end else if (tick_1hz) begin
            if (to_cnt >= TO_W'(TIMEOUT_S - 1)) begin
                state_next = RUN;
                to_next    = '0;
            end else begin
                to_next = to_cnt + TO_W'(1);
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    logic            rep_active, rep_dir, rep_first, hold_ok, rep_fire;
    logic [RP_W-1:0] rep_cnt;

    // Repeat survives only while the originating button alone stays held in an unchanged edit state.
    always_comb begin
        hold_ok  = rep_active & editing & (state_next == state) & ~(up_lvl & dn_lvl)
                 & (rep_dir ? up_lvl : dn_lvl);
        rep_fire = 1'b0;
        if (hold_ok) begin
            if (rep_first) rep_fire = (rep_cnt == RP_W'(REPEAT_DELAY - 1));
            else           rep_fire = (rep_cnt == RP_W'(REPEAT_PERIOD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_active <= 1'b0;
            rep_dir    <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (fire_up | fire_dn) begin
            rep_active <= 1'b1;
            rep_dir    <= fire_up;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (!hold_ok) begin
            rep_active <= 1'b0;
            rep_cnt    <= '0;
        end else if (rep_fire) begin
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            rep_cnt    <= rep_cnt + RP_W'(1);
        end
    end

    assign inc_pulse = fire_up | (rep_fire & rep_dir);
    assign dec_pulse = fire_dn | (rep_fire & ~rep_dir);
`else
    // Repeat timing has no effect in this build.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_unused_repeat_params
    end

    assign inc_pulse = fire_up;
    assign dec_pulse = fire_dn;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_inc_auto    <= 1'b0;
            sec_inc_manual  <= 1'b0;
            sec_dec_manual  <= 1'b0;
            min_inc_manual  <= 1'b0;
            min_dec_manual  <= 1'b0;
            hour_inc_manual <= 1'b0;
            hour_dec_manual <= 1'b0;
            blink           <= 1'b0;
            to_cnt          <= '0;
        end else begin
            sec_inc_auto    <= tick_1hz & (state == RUN);
            sec_inc_manual  <= inc_pulse & (state == SET_SEC);
            sec_dec_manual  <= dec_pulse & (state == SET_SEC);
            min_inc_manual  <= inc_pulse & (state == SET_MIN);
            min_dec_manual  <= dec_pulse & (state == SET_MIN);
            hour_inc_manual <= inc_pulse & (state == SET_HOUR);
            hour_dec_manual <= dec_pulse & (state == SET_HOUR);
            // Blink restarts dark whenever a field is newly selected.
            if (state_next == RUN || state_next != state) blink <= 1'b0;
            else if (tick_1hz)                            blink <= ~blink;
            to_cnt <= to_next;
        end
    end

    assign edit_sel = state;
endmodule
